block_mem_responder: RTL and testbench
======================================

Name: block_mem_responder

Overview:
- Responder end of the 128-bit block refill/write-back bus driven by data_cache_memory and ins_cache_memory toward main memory.
- Holds a block-addressed backing store and accepts one block read or block write at a time.
- Models a fixed access latency with a down-counter and signals completion by dropping BUSY_WAIT.
- Used as the main-memory behind either cache in testbenchCPU and in stand-alone cache benches.

Parameters:
- INDEX_BITS, 6, log2 of stored block count; depth = 2**INDEX_BITS blocks of 128 bits.
- LATENCY, 5, cycles from request acceptance to completion; legal range 1..255.
- CNT_W, 16, width of the optional performance counters.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-low reset.
- READ  input  1  block read request, level, held by the initiator until BUSY_WAIT falls.
- WRITE  input  1  block write request, level, held by the initiator until BUSY_WAIT falls.
- ADDRESS  input  28  block address (byte address [31:4]).
- WRITE_DATA  input  128  block to store; word 0 is in [31:0].
- READ_DATA  output  128  block returned on a read.
- BUSY_WAIT  output  1  high while a request is in service.
- RD_COUNT  output  CNT_W  completed reads (optional feature).
- WR_COUNT  output  CNT_W  completed writes (optional feature).

Behaviour:
- Reset (RESET low, asynchronous):
  - State goes to IDLE; BUSY_WAIT=0, READ_DATA=0, counter=0, RD_COUNT=WR_COUNT=0.
  - Storage is not cleared.
  - Reset mid-transfer aborts it; a pending write does not reach storage.
- States: IDLE, BUSY, ACK.
- IDLE:
  - On a rising edge with READ|WRITE high, latch op, ADDRESS[INDEX_BITS-1:0] and WRITE_DATA.
  - Set BUSY_WAIT<=1, load counter with LATENCY-1, go to BUSY.
  - Upper address bits above INDEX_BITS are ignored, so addresses alias modulo depth.
- READ and WRITE both high at acceptance: WRITE wins and the read is dropped. The initiator is never expected to do this.
- BUSY:
  - Counter decrements each edge.
  - Inputs are not re-sampled; latched values are used, so changes on ADDRESS or WRITE_DATA during BUSY have no effect.
- Completion edge (BUSY with counter==0):
  - Read: READ_DATA<=store[idx].
  - Write: store[idx]<=latched data; READ_DATA unchanged.
  - BUSY_WAIT<=0, go to ACK.
- Latency: with LATENCY=N, BUSY_WAIT is high for exactly N cycles. It rises at the acceptance edge and falls N edges later.
- ACK:
  - Lasts one cycle; requests are ignored, giving the initiator one cycle to drop or change its request; then return to IDLE.
  - A request still high in IDLE starts a new transaction, which is how back-to-back write-back then refill works.
  - Minimum request-to-request spacing is N+2 edges.
- READ_DATA holds its last read value until the next read completes or reset.
- Read-after-write to the same block returns the written data, because the write commits before ACK.

Optional Feature:
- Macro: BLOCK_MEM_PERF_CNT_EN.
- Defined: RD_COUNT and WR_COUNT increment on each read or write completion edge. They saturate at all-ones and do not wrap. Aborted transfers are not counted.
- Undefined: RD_COUNT and WR_COUNT are tied to 0 and no counter flops are built. The port list is identical either way.

Decomposition:
- Shared package block_mem_pkg holds:
  - state encoding constants IDLE=2'd0, BUSY=2'd1, ACK=2'd2;
  - BLOCK_W=128 and BLK_ADDR_W=28;
  - the default LATENCY.
- One natural sub-module, block_mem_latency_ctr: loadable down-counter with a zero flag, reused by both caches' miss timers.
- Storage array and FSM stay in the top module.

Test Plan:
- Reset: hold RESET low 25 ns mid-clock → BUSY_WAIT=0, READ_DATA=0, counters 0. A read of block 0x3 issued earlier and aborted by this reset leaves no trace.
- Write then read, LATENCY=5:
  - Write 0x00000004_00000003_00000002_00000001 to ADDRESS 0x0000003 → BUSY_WAIT high exactly 5 cycles, then low 1 ACK cycle.
  - Then read 0x0000003 → READ_DATA equals the written pattern at the completion edge.
- Aliasing, INDEX_BITS=6: write 0xAA..AA to 0x0000041, read 0x0000001 → 0xAA..AA.
- Simultaneous READ=WRITE=1 at 0x5 with data 0x55..55 → treated as a write. READ_DATA is unchanged, and a subsequent read of 0x5 returns 0x55..55.
- Back-to-back: keep WRITE high through ACK, then switch to READ → the second transaction starts at the first IDLE edge. Total span is 2×(5+2) edges and both results are correct.
- With BLOCK_MEM_PERF_CNT_EN and CNT_W=2: complete 5 reads → RD_COUNT saturates at 3. Without the macro, RD_COUNT and WR_COUNT stay 0.

Source files
------------

// File: rtl/block_mem_pkg.sv
// ---------------------------------------------------------------------------
// block_mem_pkg
//   Shared definitions for the block memory responder and its latency counter.
//   - state_t         : responder FSM encoding (IDLE=0, BUSY=1, ACK=2)
//   - BLOCK_W         : width of one cache block (128 bits, word 0 in [31:0])
//   - BLK_ADDR_W      : block address width (byte address [31:4])
//   - DEFAULT_LATENCY : default access latency in cycles
//   - LAT_W           : latency counter width (covers LATENCY 1..255)
//   - block_mem_dbg_t : debug snapshot of the responder's internal state
// ---------------------------------------------------------------------------
package block_mem_pkg;

   localparam int BLOCK_W         = 128;
   localparam int BLK_ADDR_W      = 28;
   localparam int DEFAULT_LATENCY = 5;
   localparam int LAT_W           = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } state_t;

   typedef struct packed {
      state_t             state;
      logic               op_wr;
      logic [LAT_W-1:0]   lat_count;
   } block_mem_dbg_t;

endpackage : block_mem_pkg

// File: rtl/block_mem_latency_ctr.sv
// ---------------------------------------------------------------------------
// block_mem_latency_ctr
//   Loadable down-counter with a zero flag, used to time a fixed access
//   latency. Load has priority over decrement; the count stops at zero.
//   Ports:
//     clk      : rising-edge clock
//     rst_n    : asynchronous active-low reset (count -> 0)
//     load     : load load_val on the next edge
//     load_val : value to load
//     dec      : decrement on the next edge (ignored while count is zero)
//     count    : current count
//     zero     : count == 0
// ---------------------------------------------------------------------------
module block_mem_latency_ctr #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule : block_mem_latency_ctr

// File: rtl/block_mem_responder.sv
// ---------------------------------------------------------------------------
// block_mem_responder
//   Main-memory responder for the 128-bit cache refill / write-back bus.
//   Holds 2**INDEX_BITS blocks, serves one block read or write at a time and
//   models a fixed LATENCY: BUSY_WAIT rises on the acceptance edge and falls
//   LATENCY edges later (the completion edge). One ACK cycle follows in which
//   requests are ignored, then the responder returns to IDLE.
//
//   Handshake: READ / WRITE are levels held by the initiator until BUSY_WAIT
//   falls. A request is accepted on any rising edge in IDLE; ADDRESS and
//   WRITE_DATA are latched there and not re-sampled. WRITE wins if both are
//   high. Completion is signalled by BUSY_WAIT falling; READ_DATA is valid
//   from that edge and holds until the next read completes or reset.
//
//   Ports:
//     CLK        : rising-edge clock
//     RESET      : asynchronous active-low reset (storage is not cleared)
//     READ       : block read request (level)
//     WRITE      : block write request (level)
//     ADDRESS    : block address; bits above INDEX_BITS are ignored (alias)
//     WRITE_DATA : block to store
//     READ_DATA  : block returned by the last completed read
//     BUSY_WAIT  : high while a request is in service
//     RD_COUNT   : saturating count of completed reads  (optional)
//     WR_COUNT   : saturating count of completed writes (optional)
//
//   Build option: define BLOCK_MEM_PERF_CNT_EN to build the saturating
//   RD_COUNT / WR_COUNT counters; otherwise both outputs are tied to zero.
// ---------------------------------------------------------------------------
module block_mem_responder
   import block_mem_pkg::*;
#(
   parameter int INDEX_BITS = 6,
   parameter int LATENCY    = DEFAULT_LATENCY,
   parameter int CNT_W      = 16
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  READ,
   input  logic                  WRITE,
   input  logic [BLK_ADDR_W-1:0] ADDRESS,
   input  logic [BLOCK_W-1:0]    WRITE_DATA,
   output logic [BLOCK_W-1:0]    READ_DATA,
   output logic                  BUSY_WAIT,
   output logic [CNT_W-1:0]      RD_COUNT,
   output logic [CNT_W-1:0]      WR_COUNT
);

   localparam int              DEPTH    = 2 ** INDEX_BITS;
   localparam logic [LAT_W-1:0] LOAD_VAL = LAT_W'(LATENCY - 1);

   state_t                  state;
   logic                    op_wr;
   logic [INDEX_BITS-1:0]   idx;
   logic [BLOCK_W-1:0]      wdata_q;
   logic [BLOCK_W-1:0]      mem [DEPTH];

   logic                    accept;
   logic                    done;
   logic                    commit_wr;
   logic [LAT_W-1:0]        lat_count;
   logic                    lat_zero;

   // Snapshot of the FSM for probes and bound checkers.
   block_mem_dbg_t          dbg;

   assign accept    = (state == IDLE) && (READ || WRITE);
   assign done      = (state == BUSY) && lat_zero;
   assign commit_wr = done && op_wr;

   // Counter is loaded with LATENCY-1 on acceptance; the completion edge is
   // the BUSY edge that sees zero, so BUSY_WAIT stays high LATENCY cycles.
   block_mem_latency_ctr #(
      .W (LAT_W)
   ) u_lat_ctr (
      .clk      (CLK),
      .rst_n    (RESET),
      .load     (accept),
      .load_val (LOAD_VAL),
      .dec      (state == BUSY),
      .count    (lat_count),
      .zero     (lat_zero)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state     <= IDLE;
         BUSY_WAIT <= 1'b0;
         READ_DATA <= '0;
         op_wr     <= 1'b0;
         idx       <= '0;
         wdata_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (READ || WRITE) begin
                  op_wr     <= WRITE;
                  idx       <= ADDRESS[INDEX_BITS-1:0];
                  wdata_q   <= WRITE_DATA;
                  BUSY_WAIT <= 1'b1;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (lat_zero) begin
                  if (!op_wr) begin
                     READ_DATA <= mem[idx];
                  end
                  BUSY_WAIT <= 1'b0;
                  state     <= ACK;
               end
            end
            ACK: begin
               state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               BUSY_WAIT <= 1'b0;
            end
         endcase
      end
   end

   // Storage has no reset. A reset mid-transfer forces IDLE, so a pending
   // write can never reach commit_wr.
   always_ff @(posedge CLK) begin
      if (commit_wr) begin
         mem[idx] <= wdata_q;
      end
   end

`ifdef BLOCK_MEM_PERF_CNT_EN
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         RD_COUNT <= '0;
         WR_COUNT <= '0;
      end else if (done) begin
         if (op_wr) begin
            if (WR_COUNT != '1) begin
               WR_COUNT <= WR_COUNT + CNT_W'(1);
            end
         end else begin
            if (RD_COUNT != '1) begin
               RD_COUNT <= RD_COUNT + CNT_W'(1);
            end
         end
      end
   end
`else
   assign RD_COUNT = '0;
   assign WR_COUNT = '0;
`endif

   assign dbg = '{state: state, op_wr: op_wr, lat_count: lat_count};

   // Aliased upper address bits and the debug snapshot have no functional
   // sink inside this block.
   logic unused_bits;
   assign unused_bits = ^{ADDRESS[BLK_ADDR_W-1:INDEX_BITS], dbg};

endmodule : block_mem_responder

// File: tb/tb_block_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_block_mem_responder
//   Self-checking bench for block_mem_responder (INDEX_BITS=6, LATENCY=5,
//   CNT_W=2). A reference memory array plus a queue of expected read data
//   model the responder; directed cases are followed by random traffic.
// ---------------------------------------------------------------------------
module tb_block_mem_responder;

   localparam int INDEX_BITS = 6;
   localparam int LAT        = 5;
   localparam int CNT_W      = 2;
   localparam int DEPTH      = 2 ** INDEX_BITS;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   // ---------------- clock / reset ----------------
   logic         CLK = 1'b0;
   logic         RESET;
   logic         READ;
   logic         WRITE;
   logic [27:0]  ADDRESS;
   logic [127:0] WRITE_DATA;
   logic [127:0] READ_DATA;
   logic         BUSY_WAIT;
   logic [CNT_W-1:0] RD_COUNT;
   logic [CNT_W-1:0] WR_COUNT;

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   block_mem_responder #(
      .INDEX_BITS (INDEX_BITS),
      .LATENCY    (LAT),
      .CNT_W      (CNT_W)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .READ       (READ),
      .WRITE      (WRITE),
      .ADDRESS    (ADDRESS),
      .WRITE_DATA (WRITE_DATA),
      .READ_DATA  (READ_DATA),
      .BUSY_WAIT  (BUSY_WAIT),
      .RD_COUNT   (RD_COUNT),
      .WR_COUNT   (WR_COUNT)
   );

   // ---------------- scoreboard / model ----------------
   int           n_checks = 0;
   int           n_errors = 0;
   logic [127:0] exp_q[$];
   logic [127:0] exp_mem [DEPTH];
   bit           exp_valid [DEPTH];
   int           written_q[$];
   logic [127:0] exp_rd;
   int           rd_cnt;
   int           wr_cnt;
   int           last_accept;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(input int c);
      return (c > CNT_MAX) ? CNT_MAX : c;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_counters(input string tag);
`ifdef BLOCK_MEM_PERF_CNT_EN
      check({tag, "_rd_count"}, 128'(RD_COUNT), 128'(sat(rd_cnt)));
      check({tag, "_wr_count"}, 128'(WR_COUNT), 128'(sat(wr_cnt)));
`else
      check({tag, "_rd_count"}, 128'(RD_COUNT), 128'(0));
      check({tag, "_wr_count"}, 128'(WR_COUNT), 128'(0));
`endif
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},  128'(BUSY_WAIT), 128'(0));
      check({tag, "_rdata"}, READ_DATA, 128'(0));
      check({tag, "_rdcnt"}, 128'(RD_COUNT), 128'(0));
      check({tag, "_wrcnt"}, 128'(WR_COUNT), 128'(0));
   endtask

   // Reset asserted mid-clock for 25 ns; model returns to its reset view.
   task automatic apply_reset(input string tag);
      #2;
      RESET = 1'b0;
      READ  = 1'b0;
      WRITE = 1'b0;
      #25;
      check_idle_outputs(tag);
      RESET  = 1'b1;
      exp_rd = '0;
      rd_cnt = 0;
      wr_cnt = 0;
      exp_q.delete();
      tick();
      check_idle_outputs({tag, "_post"});
   endtask

   // One full transaction: drive, accept, wait completion (bounded), check,
   // then the ACK edge. With hold=1 the request is left asserted into ACK.
   task automatic run_txn(input bit wr, input bit rd, input logic [27:0] addr,
                          input logic [127:0] data, input bit hold, input string tag);
      int         n;
      logic [5:0] idx;
      idx        = addr[5:0];
      WRITE      = wr;
      READ       = rd;
      ADDRESS    = addr;
      WRITE_DATA = data;
      if (!wr && rd) exp_q.push_back(exp_mem[idx]);
      tick();
      last_accept = cyc;
      check({tag, "_busy_rise"}, 128'(BUSY_WAIT), 128'(1));
      n = 1;
      while (BUSY_WAIT === 1'b1 && n < 300) begin
         // Garbage on the bus while busy must not matter.
         ADDRESS    = 28'($urandom);
         WRITE_DATA = {$urandom, $urandom, $urandom, $urandom};
         tick();
         if (BUSY_WAIT === 1'b1) n++;
      end
      check({tag, "_latency"}, 128'(n), 128'(LAT));
      if (wr) begin
         exp_mem[idx] = data;
         if (!exp_valid[idx]) begin
            exp_valid[idx] = 1'b1;
            written_q.push_back(int'(idx));
         end
         wr_cnt++;
      end else if (rd) begin
         if (exp_q.size() > 0) exp_rd = exp_q.pop_front();
         rd_cnt++;
      end
      check({tag, "_rdata"}, READ_DATA, exp_rd);
      check_counters(tag);
      if (!hold) begin
         READ  = 1'b0;
         WRITE = 1'b0;
      end
      tick();
      check({tag, "_ack_idle"}, 128'(BUSY_WAIT), 128'(0));
      check({tag, "_rdata_hold"}, READ_DATA, exp_rd);
   endtask

   // ---------------- stimulus ----------------
   localparam logic [127:0] PAT_WR  = 128'h00000004_00000003_00000002_00000001;
   localparam logic [127:0] PAT_A   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
   localparam logic [127:0] PAT_AA  = {16{8'hAA}};
   localparam logic [127:0] PAT_55  = {16{8'h55}};

   initial begin
      int first_accept;
      RESET      = 1'b0;
      READ       = 1'b0;
      WRITE      = 1'b0;
      ADDRESS    = '0;
      WRITE_DATA = '0;
      exp_rd     = '0;
      rd_cnt     = 0;
      wr_cnt     = 0;
      last_accept = 0;
      for (int i = 0; i < DEPTH; i++) begin
         exp_valid[i] = 1'b0;
         exp_mem[i]   = '0;
      end

      repeat (3) tick();
      check_idle_outputs("rst_hold");
      RESET = 1'b1;
      tick();

      // Known contents at block 7, then abort a write to it and a read of 3.
      run_txn(1'b1, 1'b0, 28'h7, PAT_A, 1'b0, "seed7");
      WRITE = 1'b1; ADDRESS = 28'h7; WRITE_DATA = ~PAT_A;
      tick(); tick();
      check("abort_wr_busy", 128'(BUSY_WAIT), 128'(1));
      apply_reset("abort_wr");
      READ = 1'b1; ADDRESS = 28'h3;
      tick(); tick(); tick();
      check("abort_rd_busy", 128'(BUSY_WAIT), 128'(1));
      apply_reset("abort_rd");
      run_txn(1'b0, 1'b1, 28'h7, '0, 1'b0, "rd7_after_abort");

      // Write then read, block 3.
      run_txn(1'b1, 1'b0, 28'h3, PAT_WR, 1'b0, "wr3");
      run_txn(1'b0, 1'b1, 28'h3, '0, 1'b0, "rd3");

      // Aliasing: 0x41 and 0x01 map to the same block.
      run_txn(1'b1, 1'b0, 28'h41, PAT_AA, 1'b0, "wr41");
      run_txn(1'b0, 1'b1, 28'h1, '0, 1'b0, "rd1_alias");

      // READ and WRITE together: write wins, READ_DATA unchanged.
      run_txn(1'b1, 1'b1, 28'h5, PAT_55, 1'b0, "rdwr5");
      run_txn(1'b0, 1'b1, 28'h5, '0, 1'b0, "rd5");

      // Back-to-back: WRITE held through ACK, then switch to READ.
      run_txn(1'b1, 1'b0, 28'h9, ~PAT_WR, 1'b1, "b2b_wr");
      first_accept = last_accept;
      run_txn(1'b0, 1'b1, 28'h9, '0, 1'b0, "b2b_rd");
      check("b2b_spacing", 128'(last_accept - first_accept), 128'(LAT + 2));

      // Random traffic with aliased upper address bits.
      for (int t = 0; t < 40; t++) begin
         logic [5:0]   ridx;
         logic [127:0] rdat;
         if (written_q.size() == 0 || $urandom_range(0, 1) == 0) begin
            ridx = 6'($urandom_range(0, DEPTH - 1));
            rdat = {$urandom, $urandom, $urandom, $urandom};
            run_txn(1'b1, 1'($urandom_range(0, 7) == 0), {22'($urandom), ridx}, rdat, 1'b0, "rnd_wr");
         end else begin
            ridx = 6'(written_q[$urandom_range(0, written_q.size() - 1)]);
            run_txn(1'b0, 1'b1, {22'($urandom), ridx}, '0, 1'b0, "rnd_rd");
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule : tb_block_mem_responder
